// File: rtl/fht_but_r2.sv
// fht_but_r2: radix-2 "two-dot" butterfly for the fast Hartley transform.
// Stage 1 forms p = cos*x1 + sin*x2 exactly. Stage 2 adds and subtracts p
// against x0 (supplied one cycle later), then halves with round-half-up.
// Optional build macro FHT_BUT_SAT_EN: clamp out-of-range results instead
// of wrapping them to D_BIT bits.
module fht_but_r2 #(
  parameter int D_BIT = 17,
  parameter int W_BIT = 12
) (
  input  logic                    iCLK,
  input  logic                    iRESET,
  input  logic signed [D_BIT-1:0] iX_0,
  input  logic signed [D_BIT-1:0] iX_1,
  input  logic signed [D_BIT-1:0] iX_2,
  input  logic signed [W_BIT-1:0] iSIN,
  input  logic signed [W_BIT-1:0] iCOS,
  output logic signed [D_BIT-1:0] oY_0,
  output logic signed [D_BIT-1:0] oY_1
);

  localparam int MW = D_BIT + W_BIT;
  localparam int PW = MW + 1;
  localparam int AW = MW + 2;

  // Adding half of 2^W_BIT before the arithmetic shift gives round-half-up.
  localparam logic signed [AW-1:0] ROUND_HALF =
    {{(AW-W_BIT){1'b0}}, 1'b1, {(W_BIT-1){1'b0}}};

`ifdef FHT_BUT_SAT_EN
  localparam logic signed [AW-1:0] Y_MAX = {{(AW-D_BIT+1){1'b0}}, {(D_BIT-1){1'b1}}};
  localparam logic signed [AW-1:0] Y_MIN = {{(AW-D_BIT+1){1'b1}}, {(D_BIT-1){1'b0}}};

  function automatic logic signed [D_BIT-1:0] narrow(input logic signed [AW-1:0] v);
    if (v > Y_MAX) begin
      narrow = Y_MAX[D_BIT-1:0];
    end else if (v < Y_MIN) begin
      narrow = Y_MIN[D_BIT-1:0];
    end else begin
      narrow = v[D_BIT-1:0];
    end
  endfunction
`endif

  logic signed [MW-1:0]    prodCos;
  logic signed [MW-1:0]    prodSin;
  logic signed [PW-1:0]    p_d;
  logic signed [PW-1:0]    p_q;
  logic signed [AW-1:0]    x0Ext;
  logic signed [AW-1:0]    pExt;
  logic signed [AW-1:0]    sum0;
  logic signed [AW-1:0]    sum1;
  logic signed [D_BIT-1:0] y0_d;
  logic signed [D_BIT-1:0] y1_d;
  logic signed [D_BIT-1:0] y0_q;
  logic signed [D_BIT-1:0] y1_q;

  // Stage 1: full-precision rotation products and their sum, no truncation.
  always_comb begin
    prodCos = $signed({{W_BIT{iX_1[D_BIT-1]}}, iX_1}) *
              $signed({{D_BIT{iCOS[W_BIT-1]}}, iCOS});
    prodSin = $signed({{W_BIT{iX_2[D_BIT-1]}}, iX_2}) *
              $signed({{D_BIT{iSIN[W_BIT-1]}}, iSIN});
    p_d     = $signed({prodCos[MW-1], prodCos}) + $signed({prodSin[MW-1], prodSin});
  end

  // Stage 1 register holding the exact rotated term.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  // Stage 2: align x0 to p's scale, add/subtract, round and narrow.
  always_comb begin
    x0Ext = $signed({{3{iX_0[D_BIT-1]}}, iX_0, {(W_BIT-1){1'b0}}});
    pExt  = $signed({p_q[PW-1], p_q});
    sum0  = x0Ext + pExt + ROUND_HALF;
    sum1  = x0Ext - pExt + ROUND_HALF;
`ifdef FHT_BUT_SAT_EN
    y0_d  = narrow(sum0 >>> W_BIT);
    y1_d  = narrow(sum1 >>> W_BIT);
`else
    y0_d  = D_BIT'(sum0 >>> W_BIT);
    y1_d  = D_BIT'(sum1 >>> W_BIT);
`endif
  end

  // Output registers for the sum and difference results.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      y0_q <= '0;
      y1_q <= '0;
    end else begin
      y0_q <= y0_d;
      y1_q <= y1_d;
    end
  end

  assign oY_0 = y0_q;
  assign oY_1 = y1_q;

endmodule

// File: tb/tb_fht_but_r2.sv
// Testbench for fht_but_r2: directed butterflies, rounding, overflow, reset
// behaviour and a randomized sweep over the eight 45-degree rotations,
// all checked against a real-arithmetic reference of the butterfly.
module tb_fht_but_r2;

  localparam int D_BIT = 17;
  localparam int W_BIT = 12;
  localparam real TWO_WU = 2048.0;

  logic                    iCLK = 1'b0;
  logic                    iRESET;
  logic signed [D_BIT-1:0] iX_0;
  logic signed [D_BIT-1:0] iX_1;
  logic signed [D_BIT-1:0] iX_2;
  logic signed [W_BIT-1:0] iSIN;
  logic signed [W_BIT-1:0] iCOS;
  logic signed [D_BIT-1:0] oY_0;
  logic signed [D_BIT-1:0] oY_1;

  int     compared   = 0;
  int     mismatched = 0;
  longint pq[$];

  int cosTab[8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
  int sinTab[8] = '{0, 724, 1024, 724, 0, -724, -1024, -724};

  fht_but_r2 #(.D_BIT(D_BIT), .W_BIT(W_BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .iX_0   (iX_0),
    .iX_1   (iX_1),
    .iX_2   (iX_2),
    .iSIN   (iSIN),
    .iCOS   (iCOS),
    .oY_0   (oY_0),
    .oY_1   (oY_1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 iCLK = ~iCLK;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Ideal butterfly value before rounding: (x0 +/- p/(2*Wu)) / 2.
  function automatic real idealY(longint x0, longint p, bit diff);
    real rot;
    rot = real'(p) / TWO_WU;
    return diff ? (real'(x0) - rot) / 2.0 : (real'(x0) + rot) / 2.0;
  endfunction

  // Reference output: ideal value rounded half-up, then fitted to D_BIT bits.
  function automatic longint refY(longint x0, longint p, bit diff);
    longint r;
    r = longint'($floor(idealY(x0, p, diff) + 0.5));
`ifdef FHT_BUT_SAT_EN
    if (r > 65535) r = 65535;
    else if (r < -65536) r = -65536;
`else
    r = r & 64'h1FFFF;
    if (r >= 65536) r = r - 131072;
`endif
    return r;
  endfunction

  // Drives one cycle: new operands plus x0 for the previous operand set,
  // then checks the results after the rising edge.
  task automatic applyStimulus(input logic signed [D_BIT-1:0] x1,
                               input logic signed [D_BIT-1:0] x2,
                               input logic signed [W_BIT-1:0] s,
                               input logic signed [W_BIT-1:0] c,
                               input logic signed [D_BIT-1:0] x0,
                               input bit checkAcc);
    longint pPrev;
    real    e0;
    real    e1;
    iX_1 = x1;
    iX_2 = x2;
    iSIN = s;
    iCOS = c;
    iX_0 = x0;
    @(posedge iCLK);
    #1;
    pPrev = pq.pop_front();
    checkOutput("model_y0", oY_0, refY(x0, pPrev, 1'b0));
    checkOutput("model_y1", oY_1, refY(x0, pPrev, 1'b1));
    if (checkAcc) begin
      e0 = real'(oY_0) - idealY(x0, pPrev, 1'b0);
      e1 = real'(oY_1) - idealY(x0, pPrev, 1'b1);
      checkOutput("acc_y0", ((e0 <= 0.5) && (e0 >= -0.5)) ? 1 : 0, 1);
      checkOutput("acc_y1", ((e1 <= 0.5) && (e1 >= -0.5)) ? 1 : 0, 1);
    end
    pq.push_back(longint'(c) * longint'(x1) + longint'(s) * longint'(x2));
    @(negedge iCLK);
  endtask

  initial begin
    int idx;
    logic signed [D_BIT-1:0] rx0;
    logic signed [D_BIT-1:0] rx1;
    logic signed [D_BIT-1:0] rx2;

    iX_0 = '0; iX_1 = '0; iX_2 = '0; iSIN = '0; iCOS = '0;
    iRESET = 1'b1;
    #1 iRESET = 1'b0;
    #1;
    checkOutput("reset_y0", oY_0, 0);
    checkOutput("reset_y1", oY_1, 0);

    @(negedge iCLK);
    iRESET = 1'b1;
    pq.delete();
    pq.push_back(0);

    // x1=2048 rotated by unit cos, then x0=100.
    applyStimulus(17'sd2048, 17'sd0, 12'sd0, 12'sd1024, 17'sd0, 1'b1);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, 17'sd100, 1'b1);
    checkOutput("ex1_y0", oY_0, 562);
    checkOutput("ex1_y1", oY_1, -462);

    // Full-scale x1=x2 rotated by 45 degrees.
    applyStimulus(17'sd32767, 17'sd32767, 12'sd724, 12'sd724, 17'sd0, 1'b1);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, 17'sd32767, 1'b1);
    checkOutput("ex2_y0", oY_0, 27967);
    checkOutput("ex2_y1", oY_1, 4800);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2 iRESET = 1'b0;
    #1;
    checkOutput("midrst_y0", oY_0, 0);
    checkOutput("midrst_y1", oY_1, 0);
    pq.delete();
    pq.push_back(0);
    repeat (2) @(negedge iCLK);
    iRESET = 1'b1;

    // First edge after release still sees the cleared p: round(5/2) = 3.
    applyStimulus(17'sd2048, 17'sd0, 12'sd0, 12'sd1024, 17'sd5, 1'b1);
    checkOutput("rstfirst_y0", oY_0, 3);
    checkOutput("rstfirst_y1", oY_1, 3);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, 17'sd100, 1'b1);
    checkOutput("rstsecond_y0", oY_0, 562);
    checkOutput("rstsecond_y1", oY_1, -462);

    // Negative full-scale operand.
    applyStimulus(-17'sd32768, 17'sd0, 12'sd0, 12'sd1024, 17'sd0, 1'b1);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, -17'sd32768, 1'b1);
    checkOutput("ex3_y0", oY_0, -24576);
    checkOutput("ex3_y1", oY_1, -8192);

    // Half-LSB rounding goes up for both signs of x0.
    applyStimulus(17'sd0, 17'sd0, 12'sd300, -12'sd500, 17'sd0, 1'b1);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, 17'sd1, 1'b1);
    checkOutput("rndpos_y0", oY_0, 1);
    checkOutput("rndpos_y1", oY_1, 1);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, -17'sd1, 1'b1);
    checkOutput("rndneg_y0", oY_0, 0);
    checkOutput("rndneg_y1", oY_1, 0);

    // Out-of-range operands: sum reaches 98304, difference is exactly -32768.
    applyStimulus(-17'sd65536, -17'sd65536, -12'sd2048, -12'sd2048, 17'sd0, 1'b1);
    applyStimulus(17'sd0, 17'sd0, 12'sd0, 12'sd0, 17'sd65535, 1'b0);
`ifdef FHT_BUT_SAT_EN
    checkOutput("ovf_y0", oY_0, 65535);
`else
    checkOutput("ovf_y0", oY_0, -32768);
`endif
    checkOutput("ovf_y1", oY_1, -32768);

    // Random in-range butterflies at every multiple of 45 degrees.
    for (int n = 0; n < 1000; n++) begin
      idx = int'($urandom_range(7));
      rx0 = D_BIT'(int'($urandom_range(65536)) - 32768);
      rx1 = D_BIT'(int'($urandom_range(65536)) - 32768);
      rx2 = D_BIT'(int'($urandom_range(65536)) - 32768);
      applyStimulus(rx1, rx2, W_BIT'(sinTab[idx]), W_BIT'(cosTab[idx]), rx0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
